// File: rtl/line_engine_pkg.sv
// Shared widths, FSM encoding and helpers for the line-drawing engine.
package line_engine_pkg;

  localparam int unsigned CoordW = 10;
  localparam int unsigned ColorW = 24;
  localparam int unsigned DeltaW = 11;
  localparam int unsigned ErrW   = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInit = 2'd1,
    StRun  = 2'd2
  } state_e;

  // Magnitude of the difference between two coordinates, zero-extended.
  function automatic logic [DeltaW-1:0] abs_diff(input logic [CoordW-1:0] a,
                                                 input logic [CoordW-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/line_engine.sv
// Bresenham line rasteriser: shadow endpoint/colour registers, a one-cycle
// setup stage, then one pixel per accepted px_valid/px_ready beat.
module line_engine
  import line_engine_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       LE_color,
  input  logic [CoordW-1:0] LE_point,
  input  logic              LE_color_valid,
  input  logic              LE_x0_valid,
  input  logic              LE_y0_valid,
  input  logic              LE_x1_valid,
  input  logic              LE_y1_valid,
  input  logic              LE_trigger,
  output logic              line_ready,
  output logic [CoordW-1:0] px_x,
  output logic [CoordW-1:0] px_y,
  output logic [ColorW-1:0] px_color,
  output logic              px_valid,
  input  logic              px_ready
);

  state_e r_state, w_state_nxt;

  logic [CoordW-1:0] r_sx0, r_sy0, r_sx1, r_sy1;
  logic [ColorW-1:0] r_scol;

  logic [CoordW-1:0]     r_x, r_y, r_xend;
  logic [DeltaW-1:0]     r_dx, r_dy;
  logic signed [ErrW-1:0] r_err;
  logic                  r_steep, r_yneg, r_primed;
  logic [ColorW-1:0]     r_col;

  logic [DeltaW-1:0]      w_adx, w_ady, w_dx, w_dy;
  logic                   w_steep, w_swap;
  logic [CoordW-1:0]      w_ax0, w_ay0, w_ax1, w_ay1, w_bx0, w_by0, w_bx1, w_by1;
  logic signed [ErrW-1:0] w_err_sub, w_err_step;
  logic [CoordW-1:0]      w_y_step;
  logic                   w_accept, w_last;
  logic                   w_unused_color;

  assign w_unused_color = ^LE_color[31:24];

  assign line_ready = (r_state == StIdle);
  // First RUN cycle only primes the output so the first beat follows setup by two edges.
  assign px_valid   = (r_state == StRun) && r_primed;
  assign px_x       = r_steep ? r_y : r_x;
  assign px_y       = r_steep ? r_x : r_y;
  assign px_color   = r_col;
  assign w_accept   = px_valid && px_ready;
  assign w_last     = (r_x == r_xend);

  // Setup: octant normalisation of the shadow endpoints.
  always_comb begin
    w_adx   = abs_diff(r_sx0, r_sx1);
    w_ady   = abs_diff(r_sy0, r_sy1);
    w_steep = w_ady > w_adx;
    w_ax0   = w_steep ? r_sy0 : r_sx0;
    w_ay0   = w_steep ? r_sx0 : r_sy0;
    w_ax1   = w_steep ? r_sy1 : r_sx1;
    w_ay1   = w_steep ? r_sx1 : r_sy1;
    w_swap  = w_ax0 > w_ax1;
    w_bx0   = w_swap ? w_ax1 : w_ax0;
    w_by0   = w_swap ? w_ay1 : w_ay0;
    w_bx1   = w_swap ? w_ax0 : w_ax1;
    w_by1   = w_swap ? w_ay0 : w_ay1;
    w_dx    = DeltaW'(w_bx1) - DeltaW'(w_bx0);
    w_dy    = abs_diff(w_by0, w_by1);
  end

  // Per-pixel error update and minor-axis step.
  always_comb begin
    w_err_sub  = r_err - $signed({1'b0, r_dy});
    w_err_step = w_err_sub[ErrW-1] ? (w_err_sub + $signed({1'b0, r_dx})) : w_err_sub;
    w_y_step   = r_yneg ? (r_y - 1'b1) : (r_y + 1'b1);
  end

  // Next-state decode; triggers outside IDLE are dropped.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (LE_trigger) w_state_nxt = StInit;
      StInit:  w_state_nxt = StRun;
      StRun:   if (w_accept && w_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Shadow registers load on their strobes regardless of state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sx0  <= '0;
      r_sy0  <= '0;
      r_sx1  <= '0;
      r_sy1  <= '0;
      r_scol <= '0;
    end else begin
      if (LE_x0_valid)    r_sx0  <= LE_point;
      if (LE_y0_valid)    r_sy0  <= LE_point;
      if (LE_x1_valid)    r_sx1  <= LE_point;
      if (LE_y1_valid)    r_sy1  <= LE_point;
      if (LE_color_valid) r_scol <= LE_color[ColorW-1:0];
    end
  end

  // Working registers: captured in INIT, stepped on each accepted beat.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_xend   <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_steep  <= 1'b0;
      r_yneg   <= 1'b0;
      r_primed <= 1'b0;
      r_col    <= '0;
    end else if (r_state == StInit) begin
      r_x      <= w_bx0;
      r_y      <= w_by0;
      r_xend   <= w_bx1;
      r_dx     <= w_dx;
      r_dy     <= w_dy;
      r_err    <= $signed(ErrW'(w_dx >> 1));
      r_steep  <= w_steep;
      r_yneg   <= !(w_by0 < w_by1);
      r_primed <= 1'b0;
      r_col    <= r_scol;
    end else if (r_state == StRun) begin
      if (!r_primed) begin
        r_primed <= 1'b1;
      end else if (w_accept) begin
        if (w_last) begin
          r_primed <= 1'b0;
        end else begin
          r_x   <= r_x + 1'b1;
          r_err <= w_err_step;
          if (w_err_sub[ErrW-1]) r_y <= w_y_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// Self-checking bench for line_engine: table of lines with hand-derived pixel
// lists fed through a scoreboard queue, plus stall / trigger-in-RUN / reset sequences.
module tb_line_engine;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] LE_color;
  logic [9:0]  LE_point;
  logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
  logic        LE_trigger;
  logic        line_ready;
  logic [9:0]  px_x, px_y;
  logic [23:0] px_color;
  logic        px_valid;
  logic        px_ready = 1'b1;

  line_engine u_dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .LE_color       (LE_color),
    .LE_point       (LE_point),
    .LE_color_valid (LE_color_valid),
    .LE_x0_valid    (LE_x0_valid),
    .LE_y0_valid    (LE_y0_valid),
    .LE_x1_valid    (LE_x1_valid),
    .LE_y1_valid    (LE_y1_valid),
    .LE_trigger     (LE_trigger),
    .line_ready     (line_ready),
    .px_x           (px_x),
    .px_y           (px_y),
    .px_color       (px_color),
    .px_valid       (px_valid),
    .px_ready       (px_ready)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [9:0]  x0, y0, x1, y1;
    logic [23:0] col;
    int          n;
    logic [19:0] pix[8];
  } vec_t;

  typedef struct {
    logic [9:0]  x, y;
    logic [23:0] c;
  } pix_t;

  vec_t vecs[8];
  int   nv = 0;
  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic rnd_mode = 1'b0;
  logic ready_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_vec(input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] col);
    vecs[nv].x0  = 10'(x0);
    vecs[nv].y0  = 10'(y0);
    vecs[nv].x1  = 10'(x1);
    vecs[nv].y1  = 10'(y1);
    vecs[nv].col = col;
    vecs[nv].n   = 0;
    nv++;
  endtask

  task automatic add_pix(input int x, input int y);
    vecs[nv-1].pix[vecs[nv-1].n] = {10'(x), 10'(y)};
    vecs[nv-1].n++;
  endtask

  task automatic push_pix(input int x, input int y, input logic [23:0] c);
    pix_t p;
    p.x = 10'(x);
    p.y = 10'(y);
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Downstream sink: always ready, or random back-pressure.
  always @(posedge Clock) begin
    #2;
    px_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Scoreboard: every accepted beat must match the head of the queue.
  always @(negedge Clock) begin
    if (px_valid && px_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", {24'd0, px_color, px_x, px_y}, {24'd0, mon_e.c, mon_e.x, mon_e.y});
      end
    end
  end

  // Writes colour and endpoints one per cycle; y1 strobe shares the trigger cycle.
  task automatic start_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [23:0] col);
    @(posedge Clock); #1;
    LE_color = {8'hA5, col}; LE_color_valid = 1'b1;
    LE_point = 10'(x0);      LE_x0_valid = 1'b1;
    @(posedge Clock); #1;
    LE_color_valid = 1'b0; LE_x0_valid = 1'b0;
    LE_point = 10'(y0); LE_y0_valid = 1'b1;
    @(posedge Clock); #1;
    LE_y0_valid = 1'b0;
    LE_point = 10'(x1); LE_x1_valid = 1'b1;
    @(posedge Clock); #1;
    LE_x1_valid = 1'b0;
    LE_point = 10'(y1); LE_y1_valid = 1'b1; LE_trigger = 1'b1;
    @(posedge Clock); #1;
    LE_y1_valid = 1'b0; LE_trigger = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(posedge Clock); #1;
    LE_trigger = 1'b1;
    @(posedge Clock); #1;
    LE_trigger = 1'b0;
  endtask

  // Counts busy cycles after the trigger edge and the first cycle showing px_valid.
  task automatic wait_done(output int low, output int first);
    low   = 0;
    first = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      if (px_valid && first < 0) first = k;
      if (line_ready) return;
      low++;
    end
    check("line_timeout", 64'(line_ready), 64'd1);
  endtask

  int         low, first;
  logic [63:0] snap;

  initial begin
    Reset = 1'b1;
    LE_color = '0; LE_point = '0; LE_trigger = 1'b0;
    LE_color_valid = 1'b0; LE_x0_valid = 1'b0; LE_y0_valid = 1'b0;
    LE_x1_valid = 1'b0; LE_y1_valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_line_ready", 64'(line_ready), 64'd1);
    check("rst_px_valid", 64'(px_valid), 64'd0);
    check("rst_px_x", 64'(px_x), 64'd0);
    check("rst_px_y", 64'(px_y), 64'd0);
    check("rst_px_color", 64'(px_color), 64'd0);
    Reset = 1'b0;

    add_vec(0, 0, 3, 0, 24'hFF0000);
    add_pix(0, 0); add_pix(1, 0); add_pix(2, 0); add_pix(3, 0);
    add_vec(2, 1, 3, 5, 24'h00FF00);
    add_pix(2, 1); add_pix(2, 2); add_pix(2, 3); add_pix(3, 4); add_pix(3, 5);
    add_vec(0, 3, 3, 0, 24'h0000FF);
    add_pix(0, 3); add_pix(1, 2); add_pix(2, 1); add_pix(3, 0);
    add_vec(3, 0, 0, 0, 24'h123456);
    add_pix(0, 0); add_pix(1, 0); add_pix(2, 0); add_pix(3, 0);
    add_vec(5, 5, 5, 5, 24'hABCDEF);
    add_pix(5, 5);
    add_vec(1023, 1023, 1020, 1021, 24'h5A5A5A);
    add_pix(1020, 1021); add_pix(1021, 1022); add_pix(1022, 1022); add_pix(1023, 1023);
    add_vec(0, 10, 0, 7, 24'hC0FFEE);
    add_pix(0, 7); add_pix(0, 8); add_pix(0, 9); add_pix(0, 10);

    // Pass 0 at full throughput (latency checked), pass 1 with random back-pressure.
    for (int pass = 0; pass < 2; pass++) begin
      rnd_mode = (pass == 1);
      for (int i = 0; i < nv; i++) begin
        for (int j = 0; j < vecs[i].n; j++)
          push_pix(int'(vecs[i].pix[j][19:10]), int'(vecs[i].pix[j][9:0]), vecs[i].col);
        start_line(int'(vecs[i].x0), int'(vecs[i].y0), int'(vecs[i].x1), int'(vecs[i].y1),
                   vecs[i].col);
        wait_done(low, first);
        if (pass == 0) begin
          check("busy_cycles", 64'(low), 64'(vecs[i].n + 2));
          check("first_valid", 64'(first), 64'd2);
        end
        check("line_drained", 64'(exp_q.size()), 64'd0);
      end
    end
    rnd_mode = 1'b0;
    ready_force = 1'b1;

    // Back-pressure for 3 cycles on the third pixel of (0,0)->(4,2).
    push_pix(0, 0, 24'h0F0F0F); push_pix(1, 0, 24'h0F0F0F); push_pix(2, 1, 24'h0F0F0F);
    push_pix(3, 1, 24'h0F0F0F); push_pix(4, 2, 24'h0F0F0F);
    start_line(0, 0, 4, 2, 24'h0F0F0F);
    repeat (4) @(posedge Clock);
    #1 ready_force = 1'b0;
    @(negedge Clock);
    snap = {24'd0, px_valid, px_color, px_x, px_y};
    check("stall_valid", 64'(px_valid), 64'd1);
    check("stall_pixel", {44'd0, px_x, px_y}, {44'd0, 10'd2, 10'd1});
    repeat (2) begin
      @(negedge Clock);
      check("stall_hold", {24'd0, px_valid, px_color, px_x, px_y}, snap);
    end
    ready_force = 1'b1;
    wait_done(low, first);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Trigger and x1 rewrite while running must not disturb the current line.
    for (int k = 0; k < 4; k++) push_pix(k, 0, 24'h00AA00);
    start_line(0, 0, 3, 0, 24'h00AA00);
    repeat (3) @(posedge Clock);
    #1;
    LE_trigger = 1'b1; LE_point = 10'd9; LE_x1_valid = 1'b1;
    @(posedge Clock); #1;
    LE_trigger = 1'b0; LE_x1_valid = 1'b0;
    wait_done(low, first);
    check("run_drained", 64'(exp_q.size()), 64'd0);
    repeat (6) begin
      @(negedge Clock);
      check("no_queued_trigger", 64'(line_ready), 64'd1);
    end
    // The rewrite did land in the shadow register: re-trigger draws to x=9.
    for (int k = 0; k < 10; k++) push_pix(k, 0, 24'h00AA00);
    pulse_trigger();
    wait_done(low, first);
    check("shadow_x1_drained", 64'(exp_q.size()), 64'd0);

    // Reset while the second pixel is presented.
    push_pix(0, 0, 24'h777777);
    start_line(0, 0, 5, 0, 24'h777777);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("abort_px_valid", 64'(px_valid), 64'd0);
    check("abort_line_ready", 64'(line_ready), 64'd1);
    check("abort_px_x", 64'(px_x), 64'd0);
    check("abort_px_color", 64'(px_color), 64'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    repeat (10) begin
      @(negedge Clock);
      check("post_reset_quiet", 64'(px_valid), 64'd0);
    end
    check("abort_drained", 64'(exp_q.size()), 64'd0);
    // Shadows were cleared: a bare trigger draws the single pixel (0,0) in colour 0.
    push_pix(0, 0, 24'h000000);
    pulse_trigger();
    wait_done(low, first);
    check("cleared_shadow_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
